ip_encode: RTL and testbench
============================

Name: ip_encode

Overview:
IPv4 transmit encoder; the transmit-side counterpart of the IPv4 receive decoder on the same 4-bit nibble stream.
- Accepts a frame request (lengths, addresses, protocol) and computes the header checksum.
- Emits a 20-byte IPv4 header (no options), then passes through the payload nibble stream.
- Sits between the transport-layer framer (upstream) and the MAC transmit nibble path (downstream).

Parameters:
TTL, 8'd64, time-to-live field value
DF, 1'b1, Don't-Fragment flag bit
ID_INIT, 16'h0000, identification value for the first frame after reset

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  frame request; sampled only in IDLE
payload_len  in  16  payload bytes; sampled with start
protocol  in  8  IPv4 protocol field; sampled with start
src_addr  in  32  source address; sampled with start
dst_addr  in  32  destination address; sampled with start
payload_valid  in  1  upstream payload nibble valid
payload_din  in  4  payload nibble, high nibble of each byte first
payload_ready  out  1  block consumes payload_din this cycle
dout_valid  out  1  dout carries a frame nibble
dout  out  4  frame nibble stream, MSB nibble first
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, frame completed
err  out  1  one-cycle pulse, request rejected or frame aborted

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, ID counter = ID_INIT.
- States: IDLE -> CALC -> HEADER -> PAYLOAD -> IDLE. Any error goes to IDLE.
- IDLE, start=1 and payload_len > 16'd65515:
  - err=1 the next cycle.
  - Stay IDLE; ID not incremented.
- IDLE, start=1 and payload_len valid (cycle 0):
  - Latch all fields.
  - total_len = payload_len + 20, 16-bit.
  - Capture current ID, then ID increments by 1 with 16-bit wrap.
  - Next state CALC.
- Header word order (10 words):
  - 0x45, 0x00 (DSCP/ECN zero)
  - total_len
  - ID
  - {1'b0, DF, 1'b0, 13'd0}
  - {TTL, protocol}
  - checksum (0 during CALC)
  - src_addr[31:16], src_addr[15:0]
  - dst_addr[31:16], dst_addr[15:0]
- CALC:
  - One word per cycle, cycles 1..10.
  - 17-bit add with end-around carry folded in each cycle.
  - Final checksum = ~sum[15:0]. If sum = 0xFFFF, transmit 0x0000.
- HEADER:
  - First header nibble (4) appears with dout_valid=1 in cycle 12.
  - 40 header nibbles on cycles 12..51, contiguous, MSB-first.
  - Latency is fixed and independent of field values.
- PAYLOAD (L = payload_len):
  - payload_ready=1 in cycles 51..50+2L.
  - A nibble sampled in cycle k appears on dout in cycle k+1, so the stream is gapless across the header/payload boundary.
  - L=0: payload_ready never asserts; frame ends after the header.
- Completion:
  - done=1 and dout_valid=0 in cycle 52+2L; state IDLE in that same cycle.
  - start is sampled in that cycle, so back-to-back frames are allowed.
- Underrun (payload_ready=1 and payload_valid=0 in cycle k):
  - Cycle k+1: dout_valid=0, err=1, payload_ready=0, state IDLE, no done.
  - The ID consumed by the aborted frame is not reused.
- While busy, start is ignored. Input fields are not re-sampled mid-frame.
- When dout_valid=0, dout=0.
- rst_n asserted mid-frame: immediate abort; no done, no err.

Test Plan:
1. Reset, then start with payload_len=95, protocol=0x11, src=C0A80001, dst=C0A800C7 and 190 continuous payload nibbles
   -> dout cycles 12..51 = 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, payload on cycles 52..241, done in cycle 242.
2. Second identical frame started in the done cycle -> ID field=0x0001, checksum=0xB860, no idle gap beyond the fixed 12-cycle latency.
3. payload_len=0 -> 40 header nibbles, total_len=0x0014, payload_ready never high, done in cycle 52.
4. payload_len=65516 -> err pulse next cycle, busy stays 0, the next accepted frame still uses the unincremented ID.
5. payload_valid dropped at the 3rd payload nibble -> err pulse, dout_valid low from the next cycle, no done, busy=0.
6. rst_n pulsed low in HEADER -> outputs 0 asynchronously, ID back to ID_INIT, a fresh start produces case-1 output exactly.

Source files
------------

// File: rtl/ip_encode.sv
// IPv4 transmit encoder: checksummed 20-byte header (no options) followed by the payload nibble stream.
// Fixed 12-cycle start-to-first-nibble latency; payload flows through one register with an upstream underrun abort.
module ip_encode #(
   parameter logic [7:0]  TTL     = 8'd64,
   parameter logic        DF      = 1'b1,
   parameter logic [15:0] ID_INIT = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] payload_len,
   input  logic [7:0]  protocol,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic        payload_valid,
   input  logic [3:0]  payload_din,
   output logic        payload_ready,
   output logic        dout_valid,
   output logic [3:0]  dout,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, CALC, HEADER, PAYLOAD} state_t;

   state_t      state, state_nxt;
   logic [3:0]  word_cnt;
   logic [5:0]  nib_cnt;
   logic [16:0] pay_cnt;
   logic [16:0] pay_nibs;
   logic [15:0] tot_len;
   logic [15:0] id_cur;
   logic [15:0] id_next;
   logic [15:0] sum;
   logic [15:0] csum;
   logic [7:0]  proto;
   logic [31:0] src;
   logic [31:0] dst;
   logic [3:0]  pay_dat;
   logic [3:0]  widx;
   logic [15:0] hdr_word;
   logic [16:0] add;
   logic [15:0] sum_fold;
   logic        accept, reject, finish, underrun, take, last_hdr;

   assign last_hdr = (nib_cnt == 6'd39);
   assign busy     = (state != IDLE);
   assign take     = payload_ready & payload_valid;

   // One header word mux serves both the checksum pass and transmission.
   assign widx = (state == CALC) ? word_cnt : nib_cnt[5:2];

   always_comb begin
      hdr_word = 16'h0000;
      case (widx)
         4'd0: hdr_word = 16'h4500;
         4'd1: hdr_word = tot_len;
         4'd2: hdr_word = id_cur;
         4'd3: hdr_word = {1'b0, DF, 14'd0};
         4'd4: hdr_word = {TTL, proto};
         4'd5: hdr_word = csum;
         4'd6: hdr_word = src[31:16];
         4'd7: hdr_word = src[15:0];
         4'd8: hdr_word = dst[31:16];
         4'd9: hdr_word = dst[15:0];
         default: hdr_word = 16'h0000;
      endcase
   end

   // End-around carry folded every cycle; the fold itself cannot overflow.
   assign add      = {1'b0, sum} + {1'b0, hdr_word};
   assign sum_fold = add[15:0] + {15'd0, add[16]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      reject        = 1'b0;
      finish        = 1'b0;
      underrun      = 1'b0;
      payload_ready = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (payload_len > 16'd65515) begin
                  reject = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = CALC;
               end
            end
         end
         CALC: begin
            if (word_cnt == 4'd10) state_nxt = HEADER;
         end
         HEADER: begin
            // First payload nibble is requested during the last header nibble.
            if (last_hdr) begin
               if (pay_nibs == 17'd0) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  payload_ready = 1'b1;
                  if (payload_valid) begin
                     state_nxt = PAYLOAD;
                  end else begin
                     underrun  = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         PAYLOAD: begin
            if (pay_cnt == pay_nibs) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end else begin
               payload_ready = 1'b1;
               if (!payload_valid) begin
                  underrun  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dout_valid = 1'b0;
      dout       = 4'h0;
      if (state == HEADER) begin
         dout_valid = 1'b1;
         case (nib_cnt[1:0])
            2'd0: dout = hdr_word[15:12];
            2'd1: dout = hdr_word[11:8];
            2'd2: dout = hdr_word[7:4];
            default: dout = hdr_word[3:0];
         endcase
      end else if (state == PAYLOAD) begin
         dout_valid = 1'b1;
         dout       = pay_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= 4'd0;
         nib_cnt  <= 6'd0;
         pay_cnt  <= 17'd0;
         pay_nibs <= 17'd0;
         tot_len  <= 16'd0;
         id_cur   <= 16'd0;
         id_next  <= ID_INIT;
         sum      <= 16'd0;
         csum     <= 16'd0;
         proto    <= 8'd0;
         src      <= 32'd0;
         dst      <= 32'd0;
         pay_dat  <= 4'd0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= finish;
         err  <= reject | underrun;
         if (accept) begin
            tot_len  <= payload_len + 16'd20;
            id_cur   <= id_next;
            id_next  <= id_next + 16'd1;
            proto    <= protocol;
            src      <= src_addr;
            dst      <= dst_addr;
            pay_nibs <= {payload_len, 1'b0};
            sum      <= 16'd0;
            csum     <= 16'd0;
            word_cnt <= 4'd0;
            nib_cnt  <= 6'd0;
            pay_cnt  <= 17'd0;
         end
         if (state == CALC) begin
            if (word_cnt == 4'd10) begin
               csum <= ~sum;
            end else begin
               sum      <= sum_fold;
               word_cnt <= word_cnt + 4'd1;
            end
         end
         if (state == HEADER) nib_cnt <= nib_cnt + 6'd1;
         if (take) begin
            pay_dat <= payload_din;
            pay_cnt <= pay_cnt + 17'd1;
         end
      end
   end

endmodule

// File: tb/tb_ip_encode.sv
// Scoreboard bench for ip_encode: the driver predicts every output event from the IPv4 header rules,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ip_encode;
   localparam logic [15:0] ID_INIT = 16'h0000;
   localparam int K_RDY = 0, K_NIB = 1, K_DONE = 2, K_ERR = 3;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] payload_len = '0;
   logic [7:0]  protocol = '0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic        payload_valid = 1'b0;
   logic [3:0]  payload_din = '0;
   logic        payload_ready, dout_valid, busy, done, err;
   logic [3:0]  dout;

   ip_encode #(.TTL(8'd64), .DF(1'b1), .ID_INIT(ID_INIT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .payload_len(payload_len),
      .protocol(protocol), .src_addr(src_addr), .dst_addr(dst_addr),
      .payload_valid(payload_valid), .payload_din(payload_din),
      .payload_ready(payload_ready), .dout_valid(dout_valid), .dout(dout),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ev_t         exp_q[$];
   int          pay[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] mdl_id = ID_INIT;
   bit          aborted = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic void push_ev(input int k, input int c, input int v);
      exp_q.push_back('{kind: k, cyc: c, val: v});
   endfunction

   task automatic mon_pop(input int kind, input int val);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d val=%0h at cycle %0d, expected nothing", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            bad++;
            $display("FAIL event: got kind=%0d cycle=%0d val=%0h, expected kind=%0d cycle=%0d val=%0h",
                     kind, cyc, val, e.kind, e.cyc, e.val);
         end
      end
   endtask

   // Monitor: every asserted output event must match the next predicted one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!dout_valid) check("dout_zero_when_invalid", {28'd0, dout}, 32'd0);
         if (payload_ready) mon_pop(K_RDY, 0);
         if (dout_valid) mon_pop(K_NIB, int'(dout));
         if (done) mon_pop(K_DONE, 0);
         if (err) mon_pop(K_ERR, 0);
      end
   end

   // Reference model: header words from the IPv4 field layout, ones-complement checksum,
   // then the full per-cycle event schedule of the frame started in cycle s.
   task automatic model_frame(input int s, input int len, input logic [7:0] proto,
                              input logic [31:0] src, input logic [31:0] dst,
                              input logic [15:0] id, input int u);
      logic [15:0] w[10];
      int unsigned acc;
      int n_out, last_rel, last_rdy, wi, ni;
      w[0] = 16'h4500;
      w[1] = 16'(len + 20);
      w[2] = id;
      w[3] = 16'h4000;
      w[4] = {8'd64, proto};
      w[5] = 16'h0000;
      w[6] = src[31:16];
      w[7] = src[15:0];
      w[8] = dst[31:16];
      w[9] = dst[15:0];
      acc = 0;
      for (int i = 0; i < 10; i++) acc += w[i];
      while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
      w[5] = ~acc[15:0];
      n_out    = (u >= 0) ? u : 2 * len;
      last_rel = 52 + n_out;
      last_rdy = (u >= 0) ? 51 + u : 50 + 2 * len;
      for (int rel = 1; rel <= last_rel; rel++) begin
         if (len > 0 && rel >= 51 && rel <= last_rdy) push_ev(K_RDY, s + rel, 0);
         if (rel >= 12 && rel <= 51) begin
            wi = (rel - 12) / 4;
            ni = (rel - 12) % 4;
            push_ev(K_NIB, s + rel, int'((w[wi] >> (12 - 4 * ni)) & 16'hF));
         end else if (rel >= 52 && rel - 52 < n_out) begin
            push_ev(K_NIB, s + rel, pay[rel - 52]);
         end
         if (rel == last_rel) push_ev((u >= 0) ? K_ERR : K_DONE, s + rel, 0);
      end
   endtask

   task automatic do_reset_mid();
      rst_n = 1'b0;
      #1;
      check("arst_dout_valid", {31'd0, dout_valid}, 32'd0);
      check("arst_dout", {28'd0, dout}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_ready", {31'd0, payload_ready}, 32'd0);
      check("arst_done_err", {30'd0, done, err}, 32'd0);
      exp_q.delete();
      mdl_id = ID_INIT;
      start = 1'b0;
      payload_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Advance to cycle target, with junk on the payload inputs while not in a payload window.
   task automatic wait_to(input int target, input int s, input int rst_rel);
      while (cyc < target) begin
         @(posedge clk);
         #1;
         if (rst_rel >= 0 && cyc == s + rst_rel) begin
            do_reset_mid();
            aborted = 1'b1;
            return;
         end
         if (cyc < target) begin
            payload_valid = 1'($urandom);
            payload_din   = 4'($urandom);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         payload_valid = 1'($urandom);
         payload_din   = 4'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one request (u = underrun nibble index or -1, rst_rel = reset cycle or -1).
   task automatic run_frame(input int len, input logic [7:0] proto, input logic [31:0] src,
                            input logic [31:0] dst, input int u, input int rst_rel);
      int s, n_need, last_rel;
      aborted = 1'b0;
      pay.delete();
      for (int j = 0; j < 2 * len && len <= 65515; j++) pay.push_back(int'($urandom_range(0, 15)));
      s = cyc;
      start       = 1'b1;
      payload_len = 16'(len);
      protocol    = proto;
      src_addr    = src;
      dst_addr    = dst;
      if (len > 65515) begin
         push_ev(K_ERR, s + 1, 0);
         @(posedge clk);
         #1;
         start = 1'b0;
         check("busy_after_reject", {31'd0, busy}, 32'd0);
         return;
      end
      model_frame(s, len, proto, src, dst, mdl_id, u);
      mdl_id++;
      @(posedge clk);
      #1;
      start       = 1'b0;
      payload_len = 16'($urandom);
      protocol    = 8'($urandom);
      src_addr    = $urandom;
      dst_addr    = $urandom;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      n_need   = (u >= 0) ? u + 1 : 2 * len;
      last_rel = 52 + ((u >= 0) ? u : 2 * len);
      for (int j = 0; j < n_need; j++) begin
         wait_to(s + 51 + j, s, rst_rel);
         if (aborted) return;
         payload_valid = (j != u);
         payload_din   = 4'(pay[j]);
      end
      wait_to(s + last_rel, s, rst_rel);
      if (aborted) return;
      payload_valid = 1'b0;
      check("busy_at_frame_end", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int r, len, u;
      repeat (3) @(posedge clk);
      #1;
      check("reset_dout_valid", {31'd0, dout_valid}, 32'd0);
      check("reset_dout", {28'd0, dout}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_ready", {31'd0, payload_ready}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_frame(95, 8'h11, 32'hC0A80001, 32'hC0A800C7, -1, -1);
      run_frame(95, 8'h11, 32'hC0A80001, 32'hC0A800C7, -1, -1);
      run_frame(0, 8'h06, $urandom, $urandom, -1, -1);
      run_frame(65516, 8'h11, $urandom, $urandom, -1, -1);
      run_frame(3, 8'h11, $urandom, $urandom, -1, -1);
      run_frame(10, 8'h11, $urandom, $urandom, 2, -1);
      idle(2);
      run_frame(95, 8'h11, 32'hC0A80001, 32'hC0A800C7, -1, 20);
      run_frame(95, 8'h11, 32'hC0A80001, 32'hC0A800C7, -1, -1);
      for (int i = 0; i < 12; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) len = 65516 + int'($urandom_range(0, 19));
         else        len = int'($urandom_range(0, 40));
         u = -1;
         if (r == 1 && len > 0) u = int'($urandom_range(0, 2 * len - 1));
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
         run_frame(len, 8'($urandom), $urandom, $urandom, u, -1);
      end
      payload_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time budget exceeded at cycle %0d, expected completion earlier", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
